axi_ar_arbiter: RTL

Shares one AXI read port between the instruction-fetch requester (port 0, fed by the fetch-side request CDC) and the data-memory requester (port 1). Runs entirely in the AXI clock domain. Arbitrates AR requests round-robin, tags each with a 1-bit ARID equal to the requester index, and limits outstanding bursts per requester. Routes R beats back to the owner by RID.

---
 rtl/axi_ar_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/axi_ar_arbiter.sv
// Two-requester AXI read-address arbiter: round-robin AR grant tagged with ARID,
// per-requester outstanding-burst limit, and combinational R routing by RID.
module axi_ar_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic              axi_clk,
    input  logic              axi_resetn,

    input  logic [ADDR_W-1:0] s0_araddr_i,
    input  logic [7:0]        s0_arlen_i,
    input  logic [2:0]        s0_arsize_i,
    input  logic [1:0]        s0_arburst_i,
    input  logic              s0_arvalid_i,
    output logic              s0_arready_o,
    output logic [DATA_W-1:0] s0_rdata_o,
    output logic [1:0]        s0_rresp_o,
    output logic              s0_rlast_o,
    output logic              s0_rvalid_o,
    input  logic              s0_rready_i,

    input  logic [ADDR_W-1:0] s1_araddr_i,
    input  logic [7:0]        s1_arlen_i,
    input  logic [2:0]        s1_arsize_i,
    input  logic [1:0]        s1_arburst_i,
    input  logic              s1_arvalid_i,
    output logic              s1_arready_o,
    output logic [DATA_W-1:0] s1_rdata_o,
    output logic [1:0]        s1_rresp_o,
    output logic              s1_rlast_o,
    output logic              s1_rvalid_o,
    input  logic              s1_rready_i,

    output logic [ADDR_W-1:0] m_araddr_o,
    output logic [7:0]        m_arlen_o,
    output logic [2:0]        m_arsize_o,
    output logic [1:0]        m_arburst_o,
    output logic              m_arid_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rid_i,
    input  logic              m_rlast_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,

    output logic              err_o
);

    localparam int            CW      = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTST);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] cnt0, cnt1;

    logic elig0, elig1, grant_any, grant_idx;
    logic r_done, dec0, dec1;

    assign elig0     = s0_arvalid_i && (cnt0 < CNT_MAX);
    assign elig1     = s1_arvalid_i && (cnt1 < CNT_MAX);
    assign grant_any = (state == IDLE) && (elig0 || elig1);
    // On a tie the requester that did not win last time is served.
    assign grant_idx = (elig0 && elig1) ? ~last_grant : elig1;

    assign s0_arready_o = axi_resetn && grant_any && !grant_idx;
    assign s1_arready_o = axi_resetn && grant_any &&  grant_idx;

    assign s0_rvalid_o = m_rvalid_i && !m_rid_i;
    assign s1_rvalid_o = m_rvalid_i &&  m_rid_i;
    assign s0_rdata_o  = m_rdata_i;
    assign s1_rdata_o  = m_rdata_i;
    assign s0_rresp_o  = m_rresp_i;
    assign s1_rresp_o  = m_rresp_i;
    assign s0_rlast_o  = m_rlast_i;
    assign s1_rlast_o  = m_rlast_i;
    assign m_rready_o  = m_rid_i ? s1_rready_i : s0_rready_i;

    assign r_done = m_rvalid_i && m_rready_o && m_rlast_i;
    assign dec0   = r_done && !m_rid_i;
    assign dec1   = r_done &&  m_rid_i;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state       <= IDLE;
            m_arvalid_o <= 1'b0;
            m_araddr_o  <= '0;
            m_arlen_o   <= '0;
            m_arsize_o  <= '0;
            m_arburst_o <= '0;
            m_arid_o    <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_arready_o || s1_arready_o) begin
                        m_araddr_o  <= grant_idx ? s1_araddr_i  : s0_araddr_i;
                        m_arlen_o   <= grant_idx ? s1_arlen_i   : s0_arlen_i;
                        m_arsize_o  <= grant_idx ? s1_arsize_i  : s0_arsize_i;
                        m_arburst_o <= grant_idx ? s1_arburst_i : s0_arburst_i;
                        m_arid_o    <= grant_idx;
                        last_grant  <= grant_idx;
                        m_arvalid_o <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_arready_i) begin
                        m_arvalid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    m_arvalid_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // A simultaneous grant and completion cancel; completion at zero is flagged, not wrapped.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            cnt0  <= '0;
            cnt1  <= '0;
            err_o <= 1'b0;
        end else begin
            if (s0_arready_o && !dec0)
                cnt0 <= cnt0 + 1'b1;
            else if (dec0 && !s0_arready_o && cnt0 != '0)
                cnt0 <= cnt0 - 1'b1;

            if (s1_arready_o && !dec1)
                cnt1 <= cnt1 + 1'b1;
            else if (dec1 && !s1_arready_o && cnt1 != '0)
                cnt1 <= cnt1 - 1'b1;

            if ((dec0 && cnt0 == '0) || (dec1 && cnt1 == '0))
                err_o <= 1'b1;
        end
    end

endmodule
